// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter that merges CH_N valid/ready channels into one output stream.
// grant and grant_idx are registered and drive the select of a downstream one-hot payload mux.
module rr_grant_arbiter #(
  parameter int CH_N  = 4,
  parameter int IDX_W = $clog2(CH_N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH_N-1:0]  in_valid,
  output logic [CH_N-1:0]  in_ready,
  output logic [CH_N-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_state, w_nextState;
  logic [CH_N-1:0]  r_grant, w_nextGrant;
  logic [IDX_W-1:0] r_grantIdx, w_nextIdx;
  logic [IDX_W-1:0] r_ptr, w_nextPtr;
  logic [IDX_W-1:0] w_ptrInc;
  logic [CH_N-1:0]  w_rearbReq;
  logic [IDX_W-1:0] w_idleWin, w_rearbWin;
  logic             w_handshake;

  // Rotating the doubled request vector puts the start channel at bit 0,
  // so the lowest set bit is the first requester at or after start.
  function automatic logic [IDX_W-1:0] arbitrate(input logic [CH_N-1:0] req,
                                                 input logic [IDX_W-1:0] start);
    logic [CH_N-1:0]  rot;
    logic [IDX_W-1:0] win;
    rot = CH_N'({req, req} >> start);
    win = '0;
    for (int j = CH_N - 1; j >= 0; j--) begin
      if (rot[j]) win = IDX_W'((int'(start) + j) % CH_N);
    end
    return win;
  endfunction

  function automatic logic [CH_N-1:0] toOneHot(input logic [IDX_W-1:0] idx);
    return {{(CH_N-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign w_ptrInc    = (r_grantIdx == IDX_W'(CH_N - 1)) ? '0 : r_grantIdx + 1'b1;
  assign w_rearbReq  = in_valid & ~r_grant;
  assign w_idleWin   = arbitrate(in_valid, r_ptr);
  assign w_rearbWin  = arbitrate(w_rearbReq, w_ptrInc);

  // Reset gates the outputs so a handshake cannot complete on the reset cycle.
  assign out_valid   = !rst && (r_state == BUSY) && |(r_grant & in_valid);
  assign w_handshake = out_valid && out_ready;
  assign in_ready    = w_handshake ? r_grant : '0;
  assign grant       = r_grant;
  assign grant_idx   = r_grantIdx;

  always_comb begin
    w_nextState = r_state;
    w_nextGrant = r_grant;
    w_nextIdx   = r_grantIdx;
    w_nextPtr   = r_ptr;
    case (r_state)
      IDLE: begin
        if (|in_valid) begin
          w_nextState = BUSY;
          w_nextGrant = toOneHot(w_idleWin);
          w_nextIdx   = w_idleWin;
        end
      end
      BUSY: begin
        if (!out_valid) begin
          w_nextState = IDLE;
          w_nextGrant = '0;
          w_nextIdx   = '0;
        end else if (out_ready) begin
          w_nextPtr = w_ptrInc;
          if (|w_rearbReq) begin
            w_nextGrant = toOneHot(w_rearbWin);
            w_nextIdx   = w_rearbWin;
          end else begin
            w_nextState = IDLE;
            w_nextGrant = '0;
            w_nextIdx   = '0;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextGrant = '0;
        w_nextIdx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_grantIdx <= '0;
      r_ptr      <= '0;
    end else begin
      r_state    <= w_nextState;
      r_grant    <= w_nextGrant;
      r_grantIdx <= w_nextIdx;
      r_ptr      <= w_nextPtr;
    end
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: directed scenarios plus random traffic, every cycle
// compared against a channel-number reference model of the round-robin rules.
module tb_rr_grant_arbiter;

  localparam int CH_N  = 4;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [CH_N-1:0]  inValid;
  logic [CH_N-1:0]  inReady;
  logic [CH_N-1:0]  grant;
  logic [IDX_W-1:0] grantIdx;
  logic             outValid;
  logic             outReady;

  int checks = 0;
  int errors = 0;

  // Model state: channel currently granted (-1 = none) and next priority channel.
  int mGranted = -1;
  int mPtr     = 0;

  rr_grant_arbiter #(.CH_N(CH_N), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .grant     (grant),
    .grant_idx (grantIdx),
    .out_valid (outValid),
    .out_ready (outReady)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [CH_N-1:0] req, input int p);
    for (int k = 0; k < CH_N; k++) begin
      if (req[(p + k) % CH_N]) return (p + k) % CH_N;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs mid-period and compares outputs against the model.
  task automatic applyStimulus(input logic r, input logic [CH_N-1:0] v, input logic o);
    logic [CH_N-1:0] expGrant;
    logic            expValid;
    @(negedge clk);
    rst = r;
    inValid = v;
    outReady = o;
    #1;
    expGrant = (mGranted >= 0) ? (4'b0001 << mGranted) : 4'b0000;
    expValid = !r && (mGranted >= 0) && v[(mGranted >= 0) ? mGranted : 0];
    checkOutput("grant", 32'(grant), 32'(expGrant));
    checkOutput("grant_idx", 32'(grantIdx), 32'((mGranted >= 0) ? mGranted : 0));
    checkOutput("out_valid", 32'(outValid), 32'(expValid));
    checkOutput("in_ready", 32'(inReady), 32'((expValid && o) ? expGrant : 4'b0000));
    checkOutput("inv_onehot0", 32'($onehot0(grant)), 32'd1);
    checkOutput("inv_subset", 32'((inReady & ~grant) == 4'b0000), 32'd1);
    checkOutput("inv_idx_match",
                32'(grant == ((grant == 4'b0000) ? 4'b0000 : (4'b0001 << grantIdx)) &&
                    (grant != 4'b0000 || grantIdx == 2'd0)), 32'd1);
    checkOutput("inv_valid_grant", 32'(!outValid || grant != 4'b0000), 32'd1);
  endtask

  // Advances one clock edge and applies the arbitration rules to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      mGranted = -1;
      mPtr     = 0;
    end else if (mGranted < 0) begin
      if (inValid != 4'b0000) mGranted = pick(inValid, mPtr);
    end else if (!inValid[mGranted]) begin
      mGranted = -1;
    end else if (outReady) begin
      mPtr     = (mGranted + 1) % CH_N;
      mGranted = pick(inValid & ~(4'b0001 << mGranted), mPtr);
    end
  endtask

  task automatic step(input logic r, input logic [CH_N-1:0] v, input logic o);
    applyStimulus(r, v, o);
    tick();
  endtask

  logic [CH_N-1:0] rotSeq [5];

  initial begin
    rst = 1'b1;
    inValid = '0;
    outReady = 1'b0;
    @(posedge clk);
    @(posedge clk);
    step(1'b1, 4'b1111, 1'b1);
    step(1'b1, 4'b1111, 1'b1);

    // Single requester on channel 2, then it drops out.
    applyStimulus(1'b0, 4'b0100, 1'b1);
    checkOutput("c2_arb_valid", 32'(outValid), 32'd0);
    tick();
    applyStimulus(1'b0, 4'b0100, 1'b1);
    checkOutput("c2_grant", 32'(grant), 32'b0100);
    checkOutput("c2_idx", 32'(grantIdx), 32'd2);
    checkOutput("c2_in_ready", 32'(inReady), 32'b0100);
    tick();
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("c2_idle", 32'(grant), 32'd0);
    tick();

    // Pointer now sits at channel 3: wrap to channel 0.
    step(1'b0, 4'b1001, 1'b1);
    applyStimulus(1'b0, 4'b1001, 1'b1);
    checkOutput("wrap_first", 32'(grant), 32'b1000);
    tick();
    applyStimulus(1'b0, 4'b1001, 1'b1);
    checkOutput("wrap_second", 32'(grant), 32'b0001);
    tick();

    // Reset lands while channel 3 is granted and the consumer is ready.
    applyStimulus(1'b1, 4'b1001, 1'b1);
    checkOutput("rstbusy_grant_pre", 32'(grant), 32'b1000);
    checkOutput("rstbusy_in_ready", 32'(inReady), 32'd0);
    checkOutput("rstbusy_out_valid", 32'(outValid), 32'd0);
    tick();
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("rstbusy_grant_post", 32'(grant), 32'd0);
    tick();

    // All channels requesting: strict rotation from channel 0.
    rotSeq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    step(1'b0, 4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'b1111, 1'b1);
      checkOutput($sformatf("rot_%0d", i), 32'(grant), 32'(rotSeq[i]));
      checkOutput($sformatf("rot_rdy_%0d", i), 32'(inReady), 32'(rotSeq[i]));
      tick();
    end

    // Grant sits at 0010; stall for five cycles then release.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'b1111, 1'b0);
      checkOutput($sformatf("stall_grant_%0d", i), 32'(grant), 32'b0010);
      checkOutput($sformatf("stall_rdy_%0d", i), 32'(inReady), 32'd0);
      tick();
    end
    applyStimulus(1'b0, 4'b1111, 1'b1);
    checkOutput("stall_release_rdy", 32'(inReady), 32'b0010);
    tick();
    applyStimulus(1'b0, 4'b1111, 1'b1);
    checkOutput("stall_next_grant", 32'(grant), 32'b0100);
    tick();

    // Random traffic, including withdrawals and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) == 0), 4'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule
